// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: opcodes and ALU FSM states.
// Used by calc_alu, calc_seq_core, the command parser and the result formatter.
package calc_pkg;

  localparam int unsigned OP_W = 2;

  // Opcode encoding shared with the parser and the result formatter
  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    FIN  = 2'b10
  } state_t;

endpackage

// File: rtl/calc_seq_core.sv
// Iterative datapath shared by shift-add multiply and restoring divide.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load           latch operands, clear accumulator and counter
//   step           perform one iteration
//   is_div         operation select latched on load (1 = divide)
//   load_lo        initial low word: multiplier (MUL) or dividend (DIV)
//   load_opd       fixed operand: multiplicand (MUL) or divisor (DIV)
//   cnt            iterations completed since load
//   result         {hi, lo}: product, or {remainder, quotient}
module calc_seq_core #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   load_lo,
  input  logic [WIDTH-1:0]   load_opd,
  output logic [CNT_W-1:0]   cnt,
  output logic [2*WIDTH-1:0] result
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opd;
  logic             div_q;

  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH:0]   trial_diff_c;
  logic             trial_ge_c;

  // Multiply: add multiplicand into the high word when the multiplier LSB is set,
  // then shift {carry, hi, lo} right by one.
  assign mul_sum_c = {1'b0, hi} + (lo[0] ? {1'b0, opd} : (WIDTH + 1)'(0));

  // Divide: shift the next dividend bit into the partial remainder and try a subtract.
  // The remainder stays below the divisor, so a successful trial fits in WIDTH bits.
  assign trial_c      = {hi, lo[WIDTH-1]};
  assign trial_diff_c = trial_c - {1'b0, opd};
  assign trial_ge_c   = (trial_c >= {1'b0, opd});

  // Iteration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      opd   <= '0;
      div_q <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      hi    <= '0;
      lo    <= load_lo;
      opd   <= load_opd;
      div_q <= is_div;
      cnt   <= '0;
    end else if (step) begin
      cnt <= cnt + CNT_W'(1);
      if (div_q) begin
        if (trial_ge_c) begin
          hi <= trial_diff_c[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi <= trial_c[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi <= mul_sum_c[WIDTH:1];
        lo <= {mul_sum_c[0], lo[WIDTH-1:1]};
      end
    end
  end

  assign result = {hi, lo};

endmodule

// File: rtl/calc_alu.sv
// Four-function calculator ALU: single-cycle ADD/SUB, iterative MUL/DIV.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      request, accepted only in IDLE
//   op         opcode (op_t encoding), sampled with start
//   src1/src2  operands A and B, sampled with start
//   busy       iterative operation in progress
//   done       one-cycle pulse, calc_res and flags valid
//   calc_res   2*WIDTH result (DIV: {remainder, quotient})
//   neg        SUB result negative
//   err        DIV by zero
module calc_alu
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] calc_res,
  output logic               neg,
  output logic               err
);

  localparam int unsigned RES_W = 2 * WIDTH;

  state_t             state;
  state_t             state_nx;

  op_t                op_c;
  logic               div_zero_c;
  logic               iter_req_c;
  logic               last_step_c;

  logic               accept_c;
  logic               commit_iter_c;
  logic               core_load_c;
  logic               core_step_c;

  logic [CNT_W-1:0]   cnt;
  logic [RES_W-1:0]   core_res;

  logic [WIDTH:0]     add_c;
  logic [WIDTH:0]     sub_c;

  logic               busy_nx;
  logic               done_nx;
  logic [RES_W-1:0]   res_nx;
  logic               neg_nx;
  logic               err_nx;

  assign op_c        = op_t'(op);
  assign div_zero_c  = (op_c == OP_DIV) && (src2 == '0);
  assign iter_req_c  = (op_c == OP_MUL) || ((op_c == OP_DIV) && !div_zero_c);
  assign last_step_c = (cnt == CNT_W'(WIDTH - 1));

  // Single-cycle results; bit WIDTH carries the carry (ADD) or borrow/sign (SUB)
  assign add_c = {1'b0, src1} + {1'b0, src2};
  assign sub_c = {1'b0, src1} - {1'b0, src2};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && iter_req_c) state_nx = ITER;
      ITER:    if (last_step_c)         state_nx = FIN;
      FIN:                              state_nx = IDLE;
      default:                          state_nx = IDLE;
    endcase
  end

  // FSM control strobes
  always_comb begin
    accept_c      = 1'b0;
    commit_iter_c = 1'b0;
    core_load_c   = 1'b0;
    core_step_c   = 1'b0;
    case (state)
      IDLE: begin
        accept_c    = start;
        core_load_c = start && iter_req_c;
      end
      ITER:    core_step_c   = 1'b1;
      FIN:     commit_iter_c = 1'b1;
      default: ;
    endcase
  end

  calc_seq_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_seq_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load_c),
    .step     (core_step_c),
    .is_div   (op_c == OP_DIV),
    .load_lo  ((op_c == OP_MUL) ? src2 : src1),
    .load_opd ((op_c == OP_MUL) ? src1 : src2),
    .cnt      (cnt),
    .result   (core_res)
  );

  // Output next values; result and flags change only on the edge that raises done
  always_comb begin
    res_nx  = calc_res;
    neg_nx  = neg;
    err_nx  = err;
    done_nx = 1'b0;
    busy_nx = (state_nx != IDLE);
    if (accept_c && !iter_req_c) begin
      done_nx = 1'b1;
      neg_nx  = 1'b0;
      err_nx  = 1'b0;
      case (op_c)
        OP_ADD: res_nx = RES_W'(add_c);
        OP_SUB: begin
          res_nx = {{(WIDTH - 1){sub_c[WIDTH]}}, sub_c};
          neg_nx = sub_c[WIDTH];
        end
        OP_DIV: begin
          res_nx = '1;
          err_nx = 1'b1;
        end
        default: ;
      endcase
    end
    if (commit_iter_c) begin
      done_nx = 1'b1;
      res_nx  = core_res;
      neg_nx  = 1'b0;
      err_nx  = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      calc_res <= '0;
      neg      <= 1'b0;
      err      <= 1'b0;
    end else begin
      busy     <= busy_nx;
      done     <= done_nx;
      calc_res <= res_nx;
      neg      <= neg_nx;
      err      <= err_nx;
    end
  end

endmodule

// File: tb/tb_calc_alu.sv
// Self-checking bench for calc_alu (WIDTH=16): vector table plus scoreboard,
// with hand sequences for back-to-back issue and reset mid-multiply.
module tb_calc_alu;
  import calc_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned RES_W = 2 * WIDTH;
  localparam int          ITER_EDGE = WIDTH + 1;
  localparam int          NVEC = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] calc_res;
  logic             neg;
  logic             err;

  always #5 clk = ~clk;

  calc_alu #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src1     (src1),
    .src2     (src2),
    .busy     (busy),
    .done     (done),
    .calc_res (calc_res),
    .neg      (neg),
    .err      (err)
  );

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [RES_W-1:0] res;
    logic             neg;
    logic             err;
    int               edge_n;  // edge index after the start edge at which done rises
    int               poke;    // >0: re-assert start (ADD) this many cycles into the op
  } vec_t;

  typedef struct {
    logic [RES_W-1:0] res;
    logic             neg;
    logic             err;
    int               edge_n;
    int               issue;
    int               id;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[NVEC];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   ndone  = 0;

  task automatic check(input string name, input int id, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s (op %0d) actual=%0h required=%0h", name, id, act, req);
    end
  endtask

  // Reference model built from plain arithmetic operators
  function automatic vec_t mk(input logic [1:0] o, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.neg = 1'b0; v.err = 1'b0; v.edge_n = 0; v.poke = 0;
    case (o)
      2'b00: v.res = RES_W'(a) + RES_W'(b);
      2'b01: begin v.res = RES_W'(a) - RES_W'(b); v.neg = (a < b); end
      2'b10: begin v.res = RES_W'(a) * RES_W'(b); v.edge_n = ITER_EDGE; end
      default: begin
        if (b == '0) begin v.res = '1; v.err = 1'b1; end
        else begin v.res = {WIDTH'(a % b), WIDTH'(a / b)}; v.edge_n = ITER_EDGE; end
      end
    endcase
    return v;
  endfunction

  // Scoreboard: every done pulse pops and checks one expected result
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (done === 1'b1) begin
      ndone++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        check("calc_res", e.id, 64'(calc_res), 64'(e.res));
        check("neg", e.id, 64'(neg), 64'(e.neg));
        check("err", e.id, 64'(err), 64'(e.err));
        check("done_edge", e.id, 64'(cyc - e.issue), 64'(e.edge_n));
      end
    end
  end

  // Drive one operation, then wait (bounded) for its done pulse
  task automatic do_op(input vec_t v, input int id, input bit b2b);
    int base;
    int n;
    int nbusy;
    exp_t e;
    if (!b2b) @(negedge clk);
    op = v.op; src1 = v.a; src2 = v.b; start = 1'b1;
    e.res = v.res; e.neg = v.neg; e.err = v.err; e.edge_n = v.edge_n;
    e.issue = cyc + 1; e.id = id;
    exp_q.push_back(e);
    base = ndone; n = 0; nbusy = 0;
    do begin
      @(negedge clk);
      if (busy) nbusy++;
      start = (v.poke > 0) && (n == v.poke);
      op    = start ? 2'(OP_ADD) : 2'($urandom);
      src1  = WIDTH'($urandom);
      src2  = WIDTH'($urandom);
      n++;
    end while (ndone == base && n < 60);
    start = 1'b0;
    if (ndone == base) begin
      checks++;
      errors++;
      $display("FAIL done_timeout (op %0d) actual=no_done required=done", id);
      exp_q.delete();
    end
    check("busy_cycles", id, 64'(nbusy), 64'(v.edge_n));
  endtask

  initial begin
    vec_t v;
    int   base;
    rst = 1'b1; start = 1'b0; op = '0; src1 = '0; src2 = '0;

    vecs[0]  = '{2'b01, 16'h0009, 16'h0001, 32'h0000_0008, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{2'b01, 16'h0001, 16'h0009, 32'hFFFF_FFF8, 1'b1, 1'b0, 0, 0};
    vecs[2]  = '{2'b00, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b0, 1'b0, 0, 0};
    vecs[3]  = '{2'b10, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 1'b0, 17, 5};
    vecs[4]  = '{2'b11, 16'd100,  16'd7,    32'h0002_000E, 1'b0, 1'b0, 17, 0};
    vecs[5]  = '{2'b11, 16'd5,    16'd0,    32'hFFFF_FFFF, 1'b0, 1'b1, 0, 0};
    vecs[6]  = mk(2'b10, 16'h1234, 16'h5678);
    vecs[7]  = mk(2'b11, 16'hFFFF, 16'h0003);
    vecs[8]  = mk(2'b11, 16'h0003, 16'h0007);
    vecs[9]  = mk(2'b01, 16'h0000, 16'h0000);
    vecs[10] = mk(2'b10, 16'h0000, 16'hABCD);
    vecs[11] = mk(2'b11, 16'hBEEF, 16'h8001);

    repeat (2) @(negedge clk);
    check("reset_busy", -1, 64'(busy), 64'd0);
    check("reset_done", -1, 64'(done), 64'd0);
    check("reset_calc_res", -1, 64'(calc_res), 64'd0);
    check("reset_neg", -1, 64'(neg), 64'd0);
    check("reset_err", -1, 64'(err), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) do_op(vecs[i], i, 1'b0);

    // Back-to-back: SUB issued in the done cycle of a MUL
    do_op(mk(2'b10, 16'h00FF, 16'h0101), 100, 1'b0);
    do_op(mk(2'b01, 16'h0010, 16'h0020), 101, 1'b1);

    // Reset in the middle of a multiply
    @(negedge clk);
    op = 2'(OP_MUL); src1 = 16'hFFFF; src2 = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_mul_busy", 200, 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_busy", 200, 64'(busy), 64'd0);
    check("async_rst_done", 200, 64'(done), 64'd0);
    check("async_rst_calc_res", 200, 64'(calc_res), 64'd0);
    base = ndone;
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("no_done_after_abort", 200, 64'(ndone - base), 64'd0);
    v = '{2'b10, 16'h0003, 16'h0005, 32'h0000_000F, 1'b0, 1'b0, 17, 0};
    do_op(v, 201, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_alu.md
Name: calc_alu

Overview:
Parametrised successor to the single-function subtraction unit in the UART calculator datapath. Accepts two WIDTH-bit unsigned operands and an opcode from the parser, then computes one of four results: add, subtract, multiply or divide. Add and subtract complete in one cycle. Multiply (shift-add) and divide (restoring) are iterative and take WIDTH+1 cycles. The result is returned on a 2*WIDTH bus, with a one-cycle done pulse and status flags for the result formatter.

Parameters:
WIDTH, 16, operand width in bits (legal 4..32); result width is 2*WIDTH.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  in  1  single system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request; sampled only while idle (parser_done equivalent).
op  in  2  opcode, sampled with start: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
src1  in  WIDTH  operand A (minuend / multiplicand / dividend).
src2  in  WIDTH  operand B (subtrahend / multiplier / divisor).
busy  out  1  high while an iterative operation is in progress.
done  out  1  one-cycle pulse; calc_res and flags are valid from this cycle.
calc_res  out  2*WIDTH  result.
neg  out  1  SUB result negative (src1 < src2).
err  out  1  DIV with src2 == 0.

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset values: busy=0, done=0, calc_res=0, neg=0, err=0, state=IDLE, counter=0.
- States:
  - IDLE: waits for start.
  - ITER: WIDTH iteration cycles.
  - FIN: one commit cycle.
- IDLE + start, with the start edge called E0:
  - op, src1 and src2 are latched at E0.
- ADD:
  - At E0, calc_res = zero-extended src1+src2 (carry lands in bit WIDTH).
  - done=1 for the following cycle; state stays IDLE.
- SUB:
  - At E0, calc_res = src1-src2 sign-extended to 2*WIDTH; neg = (src1<src2).
  - done=1 for the following cycle; state stays IDLE.
- DIV with src2==0:
  - At E0, calc_res = all ones, err=1.
  - done=1 for the following cycle; no iteration.
- MUL, and DIV with src2!=0:
  - E0: state goes to ITER; counter=0, busy=1.
  - One iteration per edge E1..E_WIDTH.
  - At E_WIDTH the state goes to FIN.
  - At E_WIDTH+1: calc_res committed, done=1, busy=0, state goes to IDLE.
  - Latency from the start edge to the done cycle is WIDTH+1 edges.
- MUL result: calc_res = full 2*WIDTH unsigned product.
- DIV result: calc_res[WIDTH-1:0] = quotient, calc_res[2*WIDTH-1:WIDTH] = remainder.
- Flags: neg and err update only at the edge that raises done. Both are cleared on any accepted start of a different condition.
- calc_res and the flags hold their values until the next result commit or reset.
- start while busy (ITER or FIN): ignored; operands and op are not re-latched.
- start in the cycle where done=1: the state is IDLE, so the start is accepted. Back-to-back operations are legal.
- Reset mid-operation: immediate return to reset values. No done is issued for the aborted operation.
- Operand inputs may change freely after E0 without affecting the result.

Decomposition:
- Shared package calc_pkg holds:
  - op_t enum: OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - state_t enum: IDLE, ITER, FIN.
  - Opcode constants shared with the parser and the result formatter.
- One sub-module, calc_seq_core:
  - Holds the iterative shift-add / restoring-divide datapath (accumulator, shift register, counter step).
  - Driven by a load strobe and a step enable from calc_alu's FSM.
  - calc_alu keeps the FSM, the single-cycle ADD/SUB path, the flags and the output registers.

Test Plan (WIDTH=16):
- SUB src1=0x0009, src2=0x0001, start 1 cycle -> done after 1 edge; calc_res=0x00000008, neg=0. Follow with SUB 0x0001-0x0009 -> calc_res=0xFFFFFFF8, neg=1.
- ADD 0xFFFF+0x0001 -> calc_res=0x00010000, done exactly 1 edge after start, busy never high.
- MUL 0xFFFF*0xFFFF -> busy high for 17 cycles; done on edge 17 after start; calc_res=0xFFFE0001. Re-assert start during ITER with op=ADD -> ignored, result unchanged.
- DIV 100/7 -> done at edge 17; calc_res=0x0002000E (r=2, q=14), err=0. Then DIV 5/0 -> done after 1 edge, calc_res=0xFFFFFFFF, err=1.
- Back-to-back: SUB asserted again in the done cycle of the previous MUL -> accepted; second done follows 1 edge later with the correct SUB result.
- Reset mid-MUL: assert rst at iteration 8 -> busy, done and calc_res go to 0 asynchronously. No done after rst is released. A new MUL 3*5 then gives 0x0000000F at latency 17.
